// File: rtl/uart_rx_fifo_if.sv
// Byte path between the UART receiver, the RX FIFO and the MMIO register block.
// The slave modport is the FIFO side; the master modport drives it.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic          i_rd_en;
  logic          i_clr_ovr;
  logic [7:0]    o_rd_data;
  logic          o_empty;
  logic          o_full;
  logic [CW-1:0] o_count;
  logic          o_overrun;
  logic          o_irq;

  modport slave (
    input  i_rx_data, i_rx_valid, i_rd_en, i_clr_ovr,
    output o_rd_data, o_empty, o_full, o_count, o_overrun, o_irq
  );

  modport master (
    output i_rx_data, i_rx_valid, i_rd_en, i_clr_ovr,
    input  o_rd_data, o_empty, o_full, o_count, o_overrun, o_irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART: captures one byte per rising edge of the receiver strobe,
// presents the head byte fall-through style, and flags dropped bytes with a sticky overrun.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int IRQ_LEVEL = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          rx_prev_q, rx_prev_d;

  logic          empty;
  logic          full;
  logic          wr_event;
  logic          rd_ok;
  logic          wr_ok;
  logic          ovr_set;

  // A write to a full FIFO is still accepted when a read frees a slot in the same cycle.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    wr_event  = bus.i_rx_valid & ~rx_prev_q;
    rd_ok     = bus.i_rd_en & ~empty;
    wr_ok     = wr_event & (~full | rd_ok);
    ovr_set   = wr_event & full & ~rd_ok;
    rx_prev_d = bus.i_rx_valid;
    wr_ptr_d  = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - CW'(1);
    end
    overrun_d = overrun_q;
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (bus.i_clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  // Edge-detector history resets high so a strobe held through reset is not captured.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_ok) begin
      mem_q[wr_ptr_q] <= bus.i_rx_data;
    end
  end

  assign bus.o_rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.o_empty   = empty;
  assign bus.o_full    = full;
  assign bus.o_count   = count_q;
  assign bus.o_overrun = overrun_q;
  assign bus.o_irq     = (count_q >= CW'(IRQ_LEVEL));
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH     = 16;
  localparam int IRQ_LEVEL = 1;

  logic i_clk;
  logic i_rst;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int         checks;
  int         errors;
  logic [7:0] model_q[$];
  bit         model_ovr;
  bit         model_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int n;
    n = model_q.size();
    check("count",   32'(bus.o_count),   32'(n));
    check("empty",   32'(bus.o_empty),   32'(n == 0));
    check("full",    32'(bus.o_full),    32'(n == DEPTH));
    check("rd_data", 32'(bus.o_rd_data), (n == 0) ? 32'h0 : 32'(model_q[0]));
    check("overrun", 32'(bus.o_overrun), 32'(model_ovr));
    check("irq",     32'(bus.o_irq),     32'(n >= IRQ_LEVEL));
  endtask

  // Drive one cycle of inputs, advance the model at the clock edge, then compare.
  task automatic applyStimulus(input bit rst, input bit valid, input logic [7:0] data,
                               input bit rd, input bit clr);
    bit wr_ev;
    bit rd_ok;
    bit dropped;
    i_rst          = rst;
    bus.i_rx_valid = valid;
    bus.i_rx_data  = data;
    bus.i_rd_en    = rd;
    bus.i_clr_ovr  = clr;
    @(posedge i_clk);
    if (rst) begin
      model_q.delete();
      model_ovr  = 1'b0;
      model_prev = 1'b1;
    end else begin
      wr_ev   = valid && !model_prev;
      rd_ok   = rd && (model_q.size() != 0);
      dropped = 1'b0;
      if (rd_ok) void'(model_q.pop_front());
      if (wr_ev) begin
        if (model_q.size() < DEPTH) model_q.push_back(data);
        else dropped = 1'b1;
      end
      if (dropped) model_ovr = 1'b1;
      else if (clr) model_ovr = 1'b0;
      model_prev = valid;
    end
    #1;
    checkOutput();
  endtask

  task automatic pushByte(input logic [7:0] data);
    applyStimulus(0, 1, data, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model_ovr  = 1'b0;
    model_prev = 1'b1;
    i_rst          = 1'b1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.i_rd_en    = 1'b0;
    bus.i_clr_ovr  = 1'b0;

    $display("[TB] reset");
    applyStimulus(1, 0, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);
    check("reset_empty", 32'(bus.o_empty), 32'd1);
    check("reset_irq",   32'(bus.o_irq),   32'd0);
    applyStimulus(0, 0, 8'h00, 0, 0);

    $display("[TB] single byte");
    applyStimulus(0, 1, 8'hA5, 0, 0);
    check("single_data", 32'(bus.o_rd_data), 32'hA5);
    check("single_irq",  32'(bus.o_irq),     32'd1);
    applyStimulus(0, 0, 8'h00, 1, 0);
    check("single_pop_empty", 32'(bus.o_empty),   32'd1);
    check("single_pop_data",  32'(bus.o_rd_data), 32'h00);

    $display("[TB] held strobe");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'h3C, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    check("held_count", 32'(bus.o_count), 32'd1);
    applyStimulus(0, 0, 8'h00, 1, 0);
    applyStimulus(0, 0, 8'h00, 1, 0);

    $display("[TB] fill and overrun");
    for (int i = 0; i < DEPTH; i++) pushByte(8'(i));
    check("fill_full",  32'(bus.o_full),  32'd1);
    check("fill_count", 32'(bus.o_count), 32'd16);
    pushByte(8'hFF);
    check("ovr_flag",  32'(bus.o_overrun), 32'd1);
    check("ovr_count", 32'(bus.o_count),   32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(bus.o_rd_data), 32'(i));
      applyStimulus(0, 0, 8'h00, 1, 0);
    end
    check("drain_empty", 32'(bus.o_empty), 32'd1);
    applyStimulus(0, 0, 8'h00, 0, 1);
    check("ovr_cleared", 32'(bus.o_overrun), 32'd0);
    applyStimulus(0, 0, 8'h00, 0, 0);

    $display("[TB] full with simultaneous read and write");
    for (int i = 0; i < DEPTH; i++) pushByte(8'h10 + 8'(i));
    applyStimulus(0, 1, 8'h77, 1, 0);
    check("rw_full_ovr",   32'(bus.o_overrun), 32'd0);
    check("rw_full_count", 32'(bus.o_count),   32'd16);
    applyStimulus(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("rw_full_last", 32'(bus.o_rd_data), 32'h77);
      applyStimulus(0, 0, 8'h00, 1, 0);
    end

    $display("[TB] wrap and set-over-clear priority");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 8'h40 + 8'(i), 0, 0);
      check("wrap_data", 32'(bus.o_rd_data), 32'h40 + 32'(i));
      applyStimulus(0, 0, 8'h00, 1, 0);
    end
    for (int i = 0; i < DEPTH; i++) pushByte(8'h80 + 8'(i));
    applyStimulus(0, 1, 8'hEE, 0, 1);
    check("set_priority", 32'(bus.o_overrun), 32'd1);
    applyStimulus(0, 0, 8'h00, 0, 0);

    $display("[TB] reset mid-stream");
    applyStimulus(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) pushByte(8'hC0 + 8'(i));
    applyStimulus(0, 1, 8'hD0, 0, 0);
    applyStimulus(1, 1, 8'hD1, 0, 0);
    check("rst_mid_count", 32'(bus.o_count),   32'd0);
    check("rst_mid_ovr",   32'(bus.o_overrun), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hD2, 0, 0);
    check("rst_held_nowrite", 32'(bus.o_count), 32'd0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    applyStimulus(0, 1, 8'hD3, 0, 0);
    check("rst_new_edge", 32'(bus.o_count), 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 1)),
                    8'($urandom),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 9) == 0));
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO capacity in bytes; SHALL be a power of two and at least 2.
REQ-002 Parameter IRQ_LEVEL, default 1, occupancy at or above which o_irq asserts; SHALL be in the range 1..DEPTH.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_rx_data  input  8  received byte from the upstream UART receiver.
REQ-006 i_rx_valid  input  1  received-byte strobe from the upstream UART receiver.
REQ-007 i_rd_en  input  1  MMIO pop request for the head byte.
REQ-008 i_clr_ovr  input  1  MMIO clear request for the overrun flag.
REQ-009 o_rd_data  output  8  head byte (first-word fall-through).
REQ-010 o_empty  output  1  FIFO holds 0 bytes.
REQ-011 o_full  output  1  FIFO holds DEPTH bytes.
REQ-012 o_count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
REQ-013 o_overrun  output  1  sticky flag: a byte was dropped.
REQ-014 o_irq  output  1  level interrupt: o_count >= IRQ_LEVEL.

Function
REQ-015 A write event SHALL occur only on a rising edge of i_rx_valid: i_rx_valid=1 in the current cycle and 0 in the previous cycle. A strobe held high for several cycles SHALL write exactly one byte.
REQ-016 On a write event with the FIFO not full, i_rx_data SHALL be stored at the write pointer. The write pointer SHALL then increment modulo DEPTH.
REQ-017 A byte written at clock edge N SHALL appear on o_rd_data, o_empty and o_count after edge N, giving one-edge latency. There SHALL be no same-cycle bypass from input to output.
REQ-018 o_rd_data SHALL equal the entry at the read pointer whenever o_empty=0. It SHALL be 8'h00 when o_empty=1.
REQ-019 When i_rd_en=1 and o_empty=0, the read pointer SHALL increment modulo DEPTH at the clock edge. When i_rd_en=1 and o_empty=1, the request SHALL be ignored with no pointer, count or flag change.
REQ-020 Write event and valid read in the same cycle: both SHALL occur and o_count SHALL be unchanged. This includes the full case, where the byte is accepted and o_overrun is not set.
REQ-021 Write event and i_rd_en in the same cycle while empty: the byte SHALL be stored, the read SHALL be ignored, and o_count SHALL become 1.
REQ-022 Write event while full with no valid read in that cycle: the byte SHALL be dropped, FIFO contents and pointers SHALL be unchanged, and o_overrun SHALL be set at that edge.
REQ-023 o_overrun SHALL remain set until i_clr_ovr=1. If a clear and a new overrun occur in the same cycle, set SHALL take priority.
REQ-024 o_count SHALL be +1 on an accepted write alone, -1 on a valid read alone, and unchanged otherwise. o_empty SHALL equal (o_count==0) and o_full SHALL equal (o_count==DEPTH).
REQ-025 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap in data ordering.
REQ-026 o_irq SHALL be combinational from o_count with no additional latency.

Reset
REQ-027 While i_rst=1 at a clock edge, the following SHALL be cleared at that edge: pointers to 0, o_count to 0, o_overrun to 0, and the rising-edge detector history to 1. This yields o_empty=1, o_full=0, o_irq=0 and o_rd_data=8'h00.
REQ-028 Storage array contents SHALL NOT require reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored bytes. A write strobe still high when reset deasserts SHALL NOT be written.
REQ-030 Reset SHALL take priority over any simultaneous write, read or clear.

Verification
REQ-031 Single byte: pulse i_rx_valid one cycle with 8'hA5 -> next cycle o_empty=0, o_count=1, o_rd_data=8'hA5, o_irq=1 (IRQ_LEVEL=1). Then i_rd_en one cycle -> o_empty=1, o_rd_data=8'h00.
REQ-032 Held strobe: i_rx_valid high 5 cycles with 8'h3C -> o_count=1 only.
REQ-033 Fill and overrun (DEPTH=16): write 8'h00..8'h0F -> o_full=1, o_count=16. Then write 8'hFF -> o_overrun=1, count stays 16. Then read 16 bytes -> 8'h00..8'h0F in order, 8'hFF absent.
REQ-034 Full with simultaneous read and write: with the FIFO full, issue read and write 8'h77 together -> no overrun, count 16, and 8'h77 is read last.
REQ-035 Wrap and priority: perform 20 write/read pairs to cross the pointer wrap -> data order preserved. Then, with the FIFO full, assert i_clr_ovr in the same cycle as an overrun write -> o_overrun=1.
REQ-036 Reset mid-stream: write 3 bytes, then assert i_rst one cycle with i_rx_valid high -> o_count=0, o_overrun=0, and no write after deassertion until i_rx_valid falls and rises again.
